// File: rtl/zxuno_ctrl_pkg.sv
// ZX-Uno control register constants: register indices, the legacy turbo port,
// default hotkey masks/values and the update-action type shared by the register logic.
package zxuno_ctrl_pkg;

    localparam logic [7:0]  MASTERCONF      = 8'h00;
    localparam logic [7:0]  MASTERMAPPER    = 8'h01;
    localparam logic [7:0]  SCANDBLCTRL     = 8'h0B;
    localparam logic [7:0]  RASTERLINE      = 8'h0C;
    localparam logic [7:0]  RASTERCTRL      = 8'h0D;

    localparam logic [15:0] PRISMSPEEDCTRL  = 16'h8E3B;

    // Video hotkey flips scandoubler/scanline/frequency bits; turbo hotkey boosts CPU speed.
    localparam logic [7:0]  VIDEO_KEY_MASK  = 8'h1D;
    localparam logic [7:0]  VIDEO_KEY_VALUE = 8'h00;
    localparam logic [7:0]  TURBO_KEY_MASK  = 8'hC0;
    localparam logic [7:0]  TURBO_KEY_VALUE = 8'hC0;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_ZXWR  = 2'd1,
        ACT_ALTWR = 2'd2,
        ACT_KEY   = 2'd3
    } ctrl_act_e;

    function automatic logic [15:0] field_mask(input int lsb, input int bits);
        logic [15:0] m;
        for (int i = 0; i < 16; i++) begin
            m[i] = ((i >= lsb) && (i < lsb + bits)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/hotkey_debounce.sv
// One hotkey front end: two-flop synchroniser, stability counter and
// registered one-cycle pulses on the debounced rising and falling edges.
module hotkey_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          rise_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;
    logic          differ_s;
    logic          flip_s;

    assign differ_s = (sync2_r != level_r);
    assign flip_s   = differ_s && (cnt_r == CW'(DEBOUNCE - 1));

    // Synchronise, count consecutive cycles of the new level and flip once it has held long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
            if (!differ_s || flip_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            level_r <= flip_s ? ~level_r : level_r;
            rise_r  <= flip_s & ~level_r;
            fall_r  <= flip_s & level_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/zxuno_ctrlreg_hotkeys.sv
// ZX-Uno control register with ZXUNO-bus and legacy I/O writes plus debounced
// toggle/momentary hotkeys; one update is applied per cycle in fixed priority.
module zxuno_ctrlreg_hotkeys
    import zxuno_ctrl_pkg::*;
#(
    parameter int                       WIDTH         = 8,
    parameter logic [7:0]               REG_ADDR      = SCANDBLCTRL,
    parameter logic [WIDTH-1:0]         RESET_VALUE   = {WIDTH{1'b0}},
    parameter logic [15:0]              ALT_PORT      = PRISMSPEEDCTRL,
    parameter int                       ALT_LSB       = 6,
    parameter int                       ALT_BITS      = 2,
    parameter int                       NUM_KEYS      = 2,
    parameter logic [NUM_KEYS-1:0]      KEY_MOMENTARY = 2'b10,
    parameter logic [NUM_KEYS*WIDTH-1:0] KEY_MASK     = {TURBO_KEY_MASK, VIDEO_KEY_MASK},
    parameter logic [NUM_KEYS*WIDTH-1:0] KEY_VALUE    = {TURBO_KEY_VALUE, VIDEO_KEY_VALUE},
    parameter int                       DEBOUNCE      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         a,
    input  logic                iorq_n,
    input  logic                wr_n,
    input  logic [7:0]          din,
    input  logic [7:0]          zxuno_addr,
    input  logic                zxuno_regrd,
    input  logic                zxuno_regwr,
    input  logic [NUM_KEYS-1:0] key,
    input  logic [NUM_KEYS-1:0] key_allow,
    output logic [7:0]          dout,
    output logic                oe_n,
    output logic [WIDTH-1:0]    ctrl,
    output logic                ctrl_changed,
    output logic [NUM_KEYS-1:0] key_active
);

    localparam logic [WIDTH-1:0] ALT_MASK = WIDTH'(field_mask(ALT_LSB, ALT_BITS));

    logic [NUM_KEYS-1:0] rise_s;
    logic [NUM_KEYS-1:0] fall_s;
    logic [NUM_KEYS-1:0] press_pend_r;
    logic [NUM_KEYS-1:0] rel_pend_r;
    logic [NUM_KEYS-1:0] key_active_r;
    logic [WIDTH-1:0]    save_r [NUM_KEYS];
    logic [WIDTH-1:0]    ctrl_r;
    logic [WIDTH-1:0]    ctrl_q_r;
    logic                ctrl_changed_r;
    logic [7:0]          dout_r;
    logic                alt_trig_q_r;

    logic                zx_wr_s;
    logic                alt_trig_s;
    logic                alt_wr_s;
    logic [NUM_KEYS-1:0] press_eff_s;
    logic [NUM_KEYS-1:0] rel_eff_s;
    logic [NUM_KEYS-1:0] evt_s;
    logic [NUM_KEYS-1:0] sel_oh_s;
    ctrl_act_e           act_s;
    logic [WIDTH-1:0]    ctrl_nxt_s;
    logic [NUM_KEYS-1:0] active_nxt_s;
    logic [NUM_KEYS-1:0] press_nxt_s;
    logic [NUM_KEYS-1:0] rel_nxt_s;
    logic [WIDTH-1:0]    save_nxt_s [NUM_KEYS];

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        hotkey_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .key   (key[g]),
            .rise  (rise_s[g]),
            .fall  (fall_s[g])
        );
    end

    assign zx_wr_s     = zxuno_regwr && (zxuno_addr == REG_ADDR);
    assign alt_trig_s  = !iorq_n && !wr_n && (a == ALT_PORT);
    assign alt_wr_s    = alt_trig_s && !alt_trig_q_r;
    assign oe_n        = !(zxuno_regrd && (zxuno_addr == REG_ADDR));

    // New edges merge with held flags so an event can be applied in the cycle it arrives.
    assign press_eff_s = press_pend_r | (rise_s & key_allow);
    assign rel_eff_s   = rel_pend_r | (fall_s & key_active_r);
    assign evt_s       = press_eff_s | rel_eff_s;
    assign sel_oh_s    = evt_s & (~evt_s + NUM_KEYS'(1));

    // Pick the single action for this cycle.
    always_comb begin
        act_s = ACT_NONE;
        if (zx_wr_s) begin
            act_s = ACT_ZXWR;
        end else if (alt_wr_s) begin
            act_s = ACT_ALTWR;
        end else if (|evt_s) begin
            act_s = ACT_KEY;
        end else begin
            act_s = ACT_NONE;
        end
    end

    // Compute next register, channel state and pending flags for the chosen action.
    always_comb begin
        ctrl_nxt_s   = ctrl_r;
        active_nxt_s = key_active_r;
        press_nxt_s  = press_eff_s;
        rel_nxt_s    = rel_eff_s;
        for (int k = 0; k < NUM_KEYS; k++) begin
            save_nxt_s[k] = save_r[k];
        end
        case (act_s)
            ACT_ZXWR: begin
                ctrl_nxt_s   = WIDTH'(din);
                active_nxt_s = {NUM_KEYS{1'b0}};
                rel_nxt_s    = {NUM_KEYS{1'b0}};
            end
            ACT_ALTWR: begin
                ctrl_nxt_s = (ctrl_r & ~ALT_MASK) | (WIDTH'(din[ALT_BITS-1:0]) << ALT_LSB);
                for (int k = 0; k < NUM_KEYS; k++) begin
                    active_nxt_s[k] = ((KEY_MASK[k*WIDTH +: WIDTH] & ALT_MASK) != {WIDTH{1'b0}})
                                      ? 1'b0 : key_active_r[k];
                    rel_nxt_s[k]    = active_nxt_s[k] & rel_eff_s[k];
                end
            end
            ACT_KEY: begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (!sel_oh_s[k]) begin
                        press_nxt_s[k] = press_eff_s[k];
                    end else if (rel_eff_s[k]) begin
                        ctrl_nxt_s      = (ctrl_r & ~KEY_MASK[k*WIDTH +: WIDTH]) | save_r[k];
                        active_nxt_s[k] = 1'b0;
                        rel_nxt_s[k]    = 1'b0;
                    end else if (!KEY_MOMENTARY[k]) begin
                        ctrl_nxt_s     = ctrl_r ^ KEY_MASK[k*WIDTH +: WIDTH];
                        press_nxt_s[k] = 1'b0;
                    end else if (key_active_r[k]) begin
                        press_nxt_s[k] = 1'b0;
                    end else begin
                        save_nxt_s[k]   = ctrl_r & KEY_MASK[k*WIDTH +: WIDTH];
                        ctrl_nxt_s      = (ctrl_r & ~KEY_MASK[k*WIDTH +: WIDTH])
                                        | (KEY_VALUE[k*WIDTH +: WIDTH] & KEY_MASK[k*WIDTH +: WIDTH]);
                        active_nxt_s[k] = 1'b1;
                        press_nxt_s[k]  = 1'b0;
                    end
                end
            end
            default: begin
                ctrl_nxt_s = ctrl_r;
            end
        endcase
    end

    // Register state, read data, change pulse and the legacy strobe history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r         <= RESET_VALUE;
            ctrl_q_r       <= RESET_VALUE;
            ctrl_changed_r <= 1'b0;
            dout_r         <= 8'h00;
            alt_trig_q_r   <= 1'b0;
            key_active_r   <= {NUM_KEYS{1'b0}};
            press_pend_r   <= {NUM_KEYS{1'b0}};
            rel_pend_r     <= {NUM_KEYS{1'b0}};
            for (int k = 0; k < NUM_KEYS; k++) begin
                save_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            ctrl_r         <= ctrl_nxt_s;
            ctrl_q_r       <= ctrl_r;
            ctrl_changed_r <= (ctrl_r != ctrl_q_r);
            dout_r         <= 8'(ctrl_r);
            alt_trig_q_r   <= alt_trig_s;
            key_active_r   <= active_nxt_s;
            press_pend_r   <= press_nxt_s;
            rel_pend_r     <= rel_nxt_s;
            for (int k = 0; k < NUM_KEYS; k++) begin
                save_r[k] <= save_nxt_s[k];
            end
        end
    end

    assign ctrl         = ctrl_r;
    assign ctrl_changed = ctrl_changed_r;
    assign dout         = dout_r;
    assign key_active   = key_active_r;

endmodule

// File: tb/tb_zxuno_ctrlreg_hotkeys.sv
// Self-checking bench for zxuno_ctrlreg_hotkeys: expected ctrl values are queued
// as stimulus is driven and popped whenever the register takes a new value.
module tb_zxuno_ctrlreg_hotkeys;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a = 16'h0000;
    logic        iorq_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [7:0]  zxuno_addr = 8'h00;
    logic        zxuno_regrd = 1'b0;
    logic        zxuno_regwr = 1'b0;
    logic [1:0]  key = 2'b00;
    logic [1:0]  key_allow = 2'b11;
    logic [7:0]  dout;
    logic        oe_n;
    logic [7:0]  ctrl;
    logic        ctrl_changed;
    logic [1:0]  key_active;

    int          n_checks = 0;
    int          n_pass = 0;
    int          unexpected = 0;
    int          pulses = 0;
    int          pulse_base;
    logic        mon_en = 1'b0;
    logic [7:0]  prev_ctrl;
    logic [7:0]  exp_q [$];

    zxuno_ctrlreg_hotkeys dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .iorq_n       (iorq_n),
        .wr_n         (wr_n),
        .din          (din),
        .zxuno_addr   (zxuno_addr),
        .zxuno_regrd  (zxuno_regrd),
        .zxuno_regwr  (zxuno_regwr),
        .key          (key),
        .key_allow    (key_allow),
        .dout         (dout),
        .oe_n         (oe_n),
        .ctrl         (ctrl),
        .ctrl_changed (ctrl_changed),
        .key_active   (key_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic zx_write(input logic [7:0] v);
        zxuno_addr  = 8'h0B;
        din         = v;
        zxuno_regwr = 1'b1;
        tick(1);
        zxuno_regwr = 1'b0;
    endtask

    // Each new ctrl value consumes the oldest expected value.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ctrl_changed === 1'b1) pulses++;
            if (ctrl !== prev_ctrl) begin
                if (exp_q.size() > 0) check("sb_ctrl", ctrl, exp_q.pop_front());
                else unexpected++;
                prev_ctrl = ctrl;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        tick(2);
        check("rst_ctrl", ctrl, 8'h00);
        check("rst_dout", dout, 8'h00);
        check("rst_changed", ctrl_changed, 1'b0);
        check("rst_active", key_active, 2'b00);
        rst_n = 1'b1;
        prev_ctrl = 8'h00;
        mon_en = 1'b1;
        tick(1);
        check("dout_after", dout, 8'h00);
        zxuno_addr = 8'h0B; zxuno_regrd = 1'b1; #1;
        check("oe_hit", oe_n, 1'b0);
        zxuno_addr = 8'h0C; #1;
        check("oe_miss", oe_n, 1'b1);
        zxuno_regrd = 1'b0;
        tick(1);

        // Toggle key: 2 sync + 4 stable + 1 apply cycles.
        pulse_base = pulses;
        exp_q.push_back(8'h1D);
        key[0] = 1'b1;
        tick(6);
        check("tog_early", ctrl, 8'h00);
        tick(1);
        check("tog_lat", ctrl, 8'h1D);
        tick(3);
        key[0] = 1'b0;
        tick(12);
        check("tog_pulses", pulses - pulse_base, 1);
        exp_q.push_back(8'h00);
        key[0] = 1'b1; tick(10); key[0] = 1'b0; tick(12);
        key[0] = 1'b1; tick(2);  key[0] = 1'b0; tick(12);
        check("glitch_ctrl", ctrl, 8'h00);
        check("glitch_drain", exp_q.size(), 0);

        // Momentary boost and restore.
        exp_q.push_back(8'h01);
        zx_write(8'h01);
        exp_q.push_back(8'hC1);
        key[1] = 1'b1; tick(12);
        check("mom_active", key_active, 2'b10);
        check("mom_dout", dout, 8'hC1);
        exp_q.push_back(8'h01);
        key[1] = 1'b0; tick(12);
        check("mom_released", key_active, 2'b00);

        // Legacy write cancels the boost; the later release is dropped.
        exp_q.push_back(8'h41);
        zx_write(8'h41);
        exp_q.push_back(8'hC1);
        key[1] = 1'b1; tick(12);
        exp_q.push_back(8'h01);
        a = 16'h8E3B; din = 8'h00; iorq_n = 1'b0; wr_n = 1'b0;
        tick(3);
        iorq_n = 1'b1; wr_n = 1'b1; a = 16'h0000;
        tick(1);
        check("cancel_active", key_active, 2'b00);
        key[1] = 1'b0; tick(12);
        check("cancel_ctrl", ctrl, 8'h01);

        // ZXUNO write collides with key0 edge: write first, toggle next cycle.
        key[0] = 1'b1;
        tick(6);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h48);
        zx_write(8'h55);
        check("coll_write", ctrl, 8'h55);
        tick(1);
        check("coll_key", ctrl, 8'h48);
        key[0] = 1'b0; tick(12);

        // Press disallowed is discarded, even once allowed again.
        key_allow = 2'b01;
        key[1] = 1'b1; tick(12);
        key_allow = 2'b11; tick(5);
        check("deny_active", key_active, 2'b00);
        key[1] = 1'b0; tick(12);
        check("deny_ctrl", ctrl, 8'h48);

        // Long legacy strobe gives exactly one update.
        pulse_base = pulses;
        exp_q.push_back(8'hC8);
        a = 16'h8E3B; din = 8'h03; iorq_n = 1'b0; wr_n = 1'b0;
        tick(10);
        din = 8'h00;
        tick(10);
        iorq_n = 1'b1; wr_n = 1'b1; a = 16'h0000;
        tick(2);
        check("strobe_ctrl", ctrl, 8'hC8);
        check("strobe_pulses", pulses - pulse_base, 1);

        // Reset mid-boost, then the still-held key counts as a fresh press.
        exp_q.push_back(8'h01);
        zx_write(8'h01);
        exp_q.push_back(8'hC1);
        key[1] = 1'b1; tick(12);
        check("boost_active", key_active, 2'b10);
        exp_q.push_back(8'h00);
        rst_n = 1'b0; #1;
        check("midrst_ctrl", ctrl, 8'h00);
        check("midrst_active", key_active, 2'b00);
        tick(2);
        rst_n = 1'b1;
        exp_q.push_back(8'hC0);
        tick(12);
        check("held_active", key_active, 2'b10);
        check("held_dout", dout, 8'hC0);
        exp_q.push_back(8'h00);
        key[1] = 1'b0; tick(12);
        check("held_release", ctrl, 8'h00);

        check("sb_drain", exp_q.size(), 0);
        check("sb_unexpected", unexpected, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
